// File: rtl/spi_counter_master.sv
// spi_counter_master: 10 Hz decimal-range counter that ships every new value as a 16-bit SPI mode-0 frame.
// Ports: clk/reset (async, active-high); run_stop/clear single-cycle debounced pulses;
// o_SCLK/o_MOSI/o_SS_N/i_MISO SPI master pins; o_rx_data/o_rx_valid last word clocked back from the slave.
module spi_counter_master #(
  parameter int TICK_DIV  = 10_000_000,
  parameter int SCLK_HALF = 50,
  parameter int CNT_MAX   = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_stop,
  input  logic        clear,
  output logic        o_SCLK,
  output logic        o_MOSI,
  output logic        o_SS_N,
  input  logic        i_MISO,
  output logic [15:0] o_rx_data,
  output logic        o_rx_valid
);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int HW = $clog2(SCLK_HALF + 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF - 1);
  localparam logic [HW-1:0] HALF      = HW'(SCLK_HALF);
  localparam logic [13:0]   CMAX      = 14'(CNT_MAX);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, STOP} state_t;
  state_t state;
  logic run, pending, tick, start;
  logic [PW-1:0] pre;
  logic [13:0] count;
  logic [HW-1:0] tmr, gap;
  logic [3:0] bit_idx;
  logic [14:0] tx;
  logic [15:0] rx, word;
  assign tick  = run && pre == PRE_LAST;
  assign start = state == IDLE && gap == '0 && pending;
  assign word  = {2'b00, count};
  // A tick or clear always wins over the frame-start clear of pending so no event is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run     <= 1'b0;
      pre     <= '0;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      run     <= run ^ run_stop;
      pre     <= (clear || tick) ? '0 : run ? pre + 1'b1 : pre;
      count   <= clear ? '0 : tick ? (count == CMAX ? '0 : count + 14'd1) : count;
      pending <= (tick || clear) ? 1'b1 : start ? 1'b0 : pending;
    end
  end
  // tx holds the not-yet-sent bits below the one currently on o_MOSI.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      o_SS_N     <= 1'b1;
      o_SCLK     <= 1'b0;
      o_MOSI     <= 1'b0;
      tmr        <= '0;
      gap        <= '0;
      bit_idx    <= '0;
      tx         <= '0;
      rx         <= '0;
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
    end else begin
      o_rx_valid <= 1'b0;
      case (state)
        IDLE:
          if (gap != '0) gap <= gap - 1'b1;
          else if (pending) begin
            o_MOSI  <= word[15];
            tx      <= word[14:0];
            bit_idx <= 4'd15;
            tmr     <= '0;
            o_SS_N  <= 1'b0;
            state   <= LOW;
          end
        LOW:
          if (tmr == HALF_LAST) begin
            tmr    <= '0;
            o_SCLK <= 1'b1;
            state  <= HIGH;
          end else tmr <= tmr + 1'b1;
        HIGH:
          if (tmr == HALF_LAST) begin
            tmr    <= '0;
            o_SCLK <= 1'b0;
            rx     <= {rx[14:0], i_MISO};
            if (bit_idx == '0) state <= STOP;
            else begin
              o_MOSI  <= tx[14];
              tx      <= {tx[13:0], 1'b0};
              bit_idx <= bit_idx - 1'b1;
              state   <= LOW;
            end
          end else tmr <= tmr + 1'b1;
        STOP:
          if (tmr == HALF_LAST) begin
            tmr        <= '0;
            o_SS_N     <= 1'b1;
            o_MOSI     <= 1'b0;
            o_rx_data  <= rx;
            o_rx_valid <= 1'b1;
            gap        <= HALF;
            state      <= IDLE;
          end else tmr <= tmr + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_counter_master.sv
// tb_spi_counter_master: directed bench with frame scoreboard and mode-0 slave for spi_counter_master.
module tb_spi_counter_master;
  localparam int TICK_DIV  = 80;
  localparam int SCLK_HALF = 2;
  localparam int CNT_MAX   = 5;
  logic clk, reset, run_stop, clear, i_MISO;
  logic o_SCLK, o_MOSI, o_SS_N, o_rx_valid;
  logic [15:0] o_rx_data;
  logic [15:0] rxw = 16'hA5C3;
  logic [15:0] expq[$];
  logic [15:0] sh, e;
  int total = 0, bad = 0, cyc = 0, frames = 0, rises = 0, fall_cyc = 0, rise_cyc = 0, first_fall = -1;
  int idx, n, c;
  bit in_frame = 0, have_prev = 0, prev_sclk = 0, pulse_chk = 0;

  spi_counter_master #(.TICK_DIV(TICK_DIV), .SCLK_HALF(SCLK_HALF), .CNT_MAX(CNT_MAX)) dut (
    .clk(clk), .reset(reset), .run_stop(run_stop), .clear(clear),
    .o_SCLK(o_SCLK), .o_MOSI(o_MOSI), .o_SS_N(o_SS_N), .i_MISO(i_MISO),
    .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_frames(input int want, input int budget);
    int b = budget;
    while (frames < want && b > 0) begin
      @(posedge clk);
      b--;
    end
    #1 chk("frame_count", frames, want);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear = 1;
    @(posedge clk); #1 clear = 0;
  endtask

  // Mode-0 slave: presents each bit before the rising edge, advances after SCLK falls.
  initial begin
    i_MISO = 0;
    forever begin
      @(negedge o_SS_N);
      idx = 15;
      i_MISO = rxw[idx];
      while (idx > 0 && !o_SS_N) begin
        @(negedge o_SCLK or posedge o_SS_N);
        #1;
        if (!o_SS_N) begin
          idx--;
          i_MISO = rxw[idx];
        end
      end
    end
  end

  // Frame monitor: collects MOSI on SCLK rises and scores each completed frame.
  always @(negedge clk) begin
    if (pulse_chk) begin
      pulse_chk = 0;
      chk("rx_valid_one_cycle", o_rx_valid, 0);
    end
    if (reset) in_frame = 0;
    else if (!in_frame && !o_SS_N) begin
      in_frame = 1;
      fall_cyc = cyc;
      rises = 0;
      sh = 0;
      if (have_prev) chk("gap_min", (fall_cyc - rise_cyc) >= SCLK_HALF + 1, 1);
      if (first_fall < 0) first_fall = cyc;
    end else if (in_frame && o_SCLK && !prev_sclk) begin
      rises++;
      sh = {sh[14:0], o_MOSI};
    end else if (in_frame && o_SS_N) begin
      chk("ss_low_len", cyc - fall_cyc, 33 * SCLK_HALF);
      chk("sclk_rises", rises, 16);
      if (expq.size() == 0) chk("scoreboard_nonempty", 0, 1);
      else begin
        e = expq.pop_front();
        chk("frame_word", sh, e);
      end
      chk("rx_valid_at_rise", o_rx_valid, 1);
      chk("rx_data", o_rx_data, 16'hA5C3);
      in_frame = 0;
      rise_cyc = cyc;
      have_prev = 1;
      frames++;
      pulse_chk = 1;
    end
    prev_sclk = o_SCLK;
  end

  initial begin
    reset = 1; run_stop = 0; clear = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sclk", o_SCLK, 0);
    chk("rst_mosi", o_MOSI, 0);
    chk("rst_ss_n", o_SS_N, 1);
    chk("rst_rx_data", o_rx_data, 0);
    chk("rst_rx_valid", o_rx_valid, 0);
    reset = 0;
    repeat (50) @(posedge clk);
    #1;
    chk("no_frame_without_event", frames, 0);
    chk("idle_ss_n", o_SS_N, 1);
    // Start running: ticks 1..13 give 1..5, wrap to 0, 1..5, clear-on-tick 0, then 1.
    @(posedge clk); #1;
    n = cyc;
    foreach (expq[i]) expq.delete(i);
    for (int k = 1; k <= 11; k++) expq.push_back(16'(k % (CNT_MAX + 1)));
    expq.push_back(16'h0000);
    expq.push_back(16'h0001);
    run_stop = 1;
    @(posedge clk); #1 run_stop = 0;
    repeat (n + 80 * 12 - cyc) @(posedge clk);
    #1 clear = 1;
    @(posedge clk); #1 clear = 0;
    repeat (n + 1 + 80 * 13 + 10 - cyc) @(posedge clk);
    #1 run_stop = 1;
    @(posedge clk); #1 run_stop = 0;
    wait_frames(13, 400);
    chk("first_fall_cycle", first_fall, n + TICK_DIV + 2);
    chk("scoreboard_drained_run", expq.size(), 0);
    repeat (200) @(posedge clk);
    #1 chk("stopped_no_ticks", frames, 13);
    // Several clears during one frame coalesce into exactly one follow-up frame.
    expq.push_back(16'h0000);
    expq.push_back(16'h0000);
    pulse_clear();
    repeat (10) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      pulse_clear();
      repeat (4) @(posedge clk);
    end
    wait_frames(15, 400);
    repeat (200) @(posedge clk);
    #1 chk("coalesced_frames", frames, 15);
    chk("scoreboard_drained_coalesce", expq.size(), 0);
    // Reset ten half-periods into a frame.
    @(posedge clk); #1;
    c = cyc;
    clear = 1;
    @(posedge clk); #1 clear = 0;
    repeat (c + 22 - cyc) @(posedge clk);
    #1 chk("midframe_ss_low", o_SS_N, 0);
    #3 reset = 1;
    #1;
    chk("midrst_ss_n", o_SS_N, 1);
    chk("midrst_sclk", o_SCLK, 0);
    chk("midrst_mosi", o_MOSI, 0);
    chk("midrst_rx_valid", o_rx_valid, 0);
    chk("midrst_rx_data", o_rx_data, 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    repeat (200) @(posedge clk);
    #1;
    chk("no_frame_after_reset", frames, 15);
    chk("ss_idle_after_reset", o_SS_N, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
